// File: rtl/pool_relu_sched.sv
// pool_relu_sched: round-robin window scheduler that shares one pool_ReLU datapath
// between N_REQ streams and tags each window result with its source id.
module pool_relu_sched #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned DATA_WID = 16,
   parameter int unsigned WIN      = 4,
   parameter int unsigned POOL_LAT = 2,
   parameter int unsigned ID_WID   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_WID-1:0] req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      pool_in_valid,
   output logic [DATA_WID-1:0]       pool_in_data,
   output logic                      pool_in_last,
   output logic [ID_WID-1:0]         res_tag,
   output logic                      res_tag_valid,
   output logic                      busy
);

   localparam int unsigned CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int unsigned SUM_W = ID_WID + 1;
   localparam int unsigned TAG_W = ID_WID + 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t              state, state_d;
   logic [ID_WID-1:0]   owner, owner_d;
   logic [ID_WID-1:0]   rr_ptr, rr_ptr_d;
   logic [ID_WID-1:0]   pick;
   logic [ID_WID-1:0]   src_q;
   logic [CNT_W-1:0]    beat_cnt, beat_cnt_d;
   logic [N_REQ-1:0]    ready_d;
   logic                busy_d;
   logic                accept;
   logic                win_end;
   logic [SUM_W-1:0]    cand;
   logic [DATA_WID-1:0] req_word [N_REQ];
   logic [TAG_W-1:0]    tag_pipe [POOL_LAT];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign req_word[g] = req_data[g*DATA_WID +: DATA_WID];
   end

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      pick = rr_ptr;
      cand = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_ptr} + SUM_W'(i);
         if (cand >= SUM_W'(N_REQ)) begin
            cand = cand - SUM_W'(N_REQ);
         end
         if (req_valid[cand[ID_WID-1:0]]) begin
            pick = cand[ID_WID-1:0];
         end
      end
   end

   // Window lock: next state, counters and the registered ready/busy values.
   always_comb begin
      state_d    = state;
      owner_d    = owner;
      rr_ptr_d   = rr_ptr;
      beat_cnt_d = beat_cnt;
      accept     = 1'b0;
      win_end    = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               owner_d    = pick;
               beat_cnt_d = '0;
               state_d    = LOCK;
            end
         end
         LOCK: begin
            accept = req_valid[owner];
            if (accept) begin
               if (beat_cnt == CNT_W'(WIN - 1)) begin
                  win_end    = 1'b1;
                  beat_cnt_d = '0;
                  rr_ptr_d   = (owner == ID_WID'(N_REQ - 1)) ? '0 : owner + 1'b1;
                  state_d    = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d == LOCK);
      ready_d = '0;
      if (state_d == LOCK) begin
         ready_d[owner_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         owner         <= '0;
         rr_ptr        <= '0;
         beat_cnt      <= '0;
         req_ready     <= '0;
         busy          <= 1'b0;
         pool_in_valid <= 1'b0;
         pool_in_data  <= '0;
         pool_in_last  <= 1'b0;
         src_q         <= '0;
         for (int i = 0; i < POOL_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         state         <= state_d;
         owner         <= owner_d;
         rr_ptr        <= rr_ptr_d;
         beat_cnt      <= beat_cnt_d;
         req_ready     <= ready_d;
         busy          <= busy_d;
         pool_in_valid <= accept;
         pool_in_last  <= win_end;
         if (accept) begin
            pool_in_data <= req_word[owner];
            src_q        <= owner;
         end
         // {last, source} travels alongside the beat through the datapath latency.
         tag_pipe[0] <= {pool_in_last, src_q};
         for (int i = 1; i < POOL_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign res_tag_valid = tag_pipe[POOL_LAT-1][ID_WID];
   assign res_tag       = tag_pipe[POOL_LAT-1][ID_WID-1:0];

endmodule

// File: tb/tb_pool_relu_sched.sv
// tb_pool_relu_sched: directed scenarios plus randomized valid traffic, checked
// against a window-level reference model running on the falling clock edge.
module tb_pool_relu_sched;

   localparam int unsigned N_REQ    = 4;
   localparam int unsigned DATA_WID = 16;
   localparam int unsigned WIN      = 4;
   localparam int unsigned POOL_LAT = 2;
   localparam int unsigned ID_WID   = 2;

   logic                      clk = 1'b0;
   logic                      reset = 1'b0;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ*DATA_WID-1:0] req_data;
   logic [N_REQ-1:0]          req_ready;
   logic                      pool_in_valid;
   logic [DATA_WID-1:0]       pool_in_data;
   logic                      pool_in_last;
   logic [ID_WID-1:0]         res_tag;
   logic                      res_tag_valid;
   logic                      busy;

   pool_relu_sched #(
      .N_REQ(N_REQ), .DATA_WID(DATA_WID), .WIN(WIN), .POOL_LAT(POOL_LAT), .ID_WID(ID_WID)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .pool_in_valid(pool_in_valid), .pool_in_data(pool_in_data),
      .pool_in_last(pool_in_last), .res_tag(res_tag), .res_tag_valid(res_tag_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [N_REQ-1:0] v, input int p);
      for (int k = 0; k < N_REQ; k++) begin
         if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
      end
      return -1;
   endfunction

   task automatic set_data(input int i, input logic [DATA_WID-1:0] v);
      req_data[i*DATA_WID +: DATA_WID] = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, req_ready, 0);
      chk({tag, "_pvalid"}, pool_in_valid, 0);
      chk({tag, "_pdata"}, pool_in_data, 0);
      chk({tag, "_plast"}, pool_in_last, 0);
      chk({tag, "_tag"}, res_tag, 0);
      chk({tag, "_tagv"}, res_tag_valid, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Called just after a rising edge; asserts reset mid-cycle and releases it later.
   task automatic do_reset(input string tag);
      req_valid = '0;
      #2 reset = 1'b0;
      #1 chk_zero(tag);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      tick();
   endtask

   // ---------------- reference model (falling edge) ----------------
   logic                rnd_mode = 1'b0;
   logic                m_p_busy, m_p_acc, m_p_last, m_acc, m_lst;
   logic [N_REQ-1:0]    m_p_valid;
   logic [DATA_WID-1:0] m_p_data, m_dat;
   int                  m_owner, m_rr, m_beats, m_exp;
   logic                hist_l [POOL_LAT+1];
   int                  hist_o [POOL_LAT+1];
   int                  wins = 0;
   int                  pulses = 0;
   logic [13:0]         mon_seq [N_REQ];
   logic [1:0]          m_src;
   int                  grp_pos, grp_src;

   always @(negedge clk) begin
      if (!reset) begin
         m_p_busy = 1'b0; m_p_acc = 1'b0; m_p_last = 1'b0; m_p_valid = '0; m_p_data = '0;
         m_owner = 0; m_rr = 0; m_beats = 0; grp_pos = 0; grp_src = 0;
         for (int k = 0; k <= POOL_LAT; k++) begin
            hist_l[k] = 1'b0;
            hist_o[k] = 0;
         end
      end else begin
         chk("pool_in_valid", pool_in_valid, 32'(m_p_acc));
         if (m_p_acc) begin
            chk("pool_in_data", pool_in_data, m_p_data);
            chk("pool_in_last", pool_in_last, 32'(m_p_last));
         end
         if (rnd_mode && pool_in_valid) begin
            m_src = pool_in_data[15:14];
            chk("stream_order", pool_in_data[13:0], mon_seq[m_src]);
            mon_seq[m_src] = pool_in_data[13:0] + 14'd1;
            if (grp_pos != 0) chk("group_src", m_src, grp_src);
            chk("group_last", pool_in_last, 32'(grp_pos == int'(WIN) - 1));
            grp_src = int'(m_src);
            grp_pos = (grp_pos == int'(WIN) - 1) ? 0 : grp_pos + 1;
         end
         chk("res_tag_valid", res_tag_valid, 32'(hist_l[POOL_LAT]));
         if (hist_l[POOL_LAT]) chk("res_tag", res_tag, hist_o[POOL_LAT]);
         if (res_tag_valid) pulses++;
         for (int k = POOL_LAT; k > 0; k--) begin
            hist_l[k] = hist_l[k-1];
            hist_o[k] = hist_o[k-1];
         end
         chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
         chk("busy_vs_ready", busy, 32'(|req_ready));
         if (!m_p_busy) begin
            if (m_p_valid != '0) begin
               m_exp = first_from(m_p_valid, m_rr);
               chk("grant", req_ready, 32'(1) << m_exp);
               m_owner = m_exp;
               m_beats = 0;
            end else begin
               chk("idle_ready", req_ready, 0);
            end
         end else if (m_p_acc && m_p_last) begin
            chk("bubble", req_ready, 0);
         end else begin
            chk("lock_ready", req_ready, 32'(1) << m_owner);
         end
         m_acc = busy && ((req_valid & req_ready) != '0);
         m_lst = 1'b0;
         m_dat = '0;
         if (m_acc) begin
            m_dat = req_data[m_owner*DATA_WID +: DATA_WID];
            m_lst = (m_beats == int'(WIN) - 1);
            m_beats++;
            if (m_lst) begin
               m_rr = (m_owner + 1) % N_REQ;
               m_beats = 0;
               wins++;
            end
         end
         hist_l[0] = m_acc && m_lst;
         hist_o[0] = m_owner;
         m_p_busy = busy; m_p_valid = req_valid; m_p_acc = m_acc;
         m_p_data = m_dat; m_p_last = m_lst;
      end
   end

   // ---------------- directed + random stimulus ----------------
   logic [DATA_WID-1:0] vals [4];
   logic [N_REQ-1:0]    xfer;
   logic [13:0]         drv_seq [N_REQ];
   int                  last_pulse, n_pulse, w0, p0;

   initial begin
      req_valid = '0;
      req_data  = '0;
      vals[0] = 16'd5; vals[1] = 16'd9; vals[2] = 16'd3; vals[3] = 16'd7;
      for (int i = 0; i < N_REQ; i++) begin
         drv_seq[i] = '0;
         mon_seq[i] = '0;
      end
      #3 chk_zero("reset_state");
      @(posedge clk);
      #2 reset = 1'b1;
      tick();

      // Single requester 2, data 5,9,3,7.
      req_valid = 4'b0100;
      set_data(2, vals[0]);
      chk("t1_idle_ready", req_ready, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         set_data(2, vals[k]);
         chk("t1_ready", req_ready, 4'b0100);
         tick();
         chk("t1_pin_data", pool_in_data, vals[k]);
         chk("t1_pin_last", pool_in_last, 32'(k == 3));
      end
      req_valid = '0;
      chk("t1_busy_after", busy, 0);
      chk("t1_tagv_early", res_tag_valid, 0);
      tick();
      chk("t1_tagv_early2", res_tag_valid, 0);
      tick();
      chk("t1_tagv", res_tag_valid, 1);
      chk("t1_tag", res_tag, 2);
      tick();
      chk("t1_tagv_after", res_tag_valid, 0);

      // All four valid from reset: order 0,1,2,3,0 with one bubble each.
      do_reset("t2_rst");
      req_valid = 4'b1111;
      for (int w = 0; w < 5; w++) begin
         chk("t2_bubble", req_ready, 0);
         tick();
         for (int b = 0; b < 4; b++) begin
            chk("t2_ready", req_ready, 32'(1) << (w % 4));
            tick();
         end
      end

      // Requester 1 holds its lock across a 5-cycle valid gap while 3 waits.
      req_valid = 4'b1010;
      chk("t3_idle", req_ready, 0);
      tick();
      for (int b = 0; b < 2; b++) begin
         chk("t3_ready", req_ready, 4'b0010);
         tick();
      end
      req_valid = 4'b1000;
      for (int h = 0; h < 5; h++) begin
         tick();
         chk("t3_hold_ready", req_ready, 4'b0010);
         chk("t3_hold_pvalid", pool_in_valid, 0);
      end
      req_valid = 4'b1010;
      tick();
      tick();
      chk("t3_end_idle", req_ready, 0);
      tick();
      chk("t3_next_owner", req_ready, 4'b1000);
      req_valid = 4'b1000;
      for (int b = 0; b < 4; b++) tick();

      // Abort a window of requester 2 with an asynchronous reset.
      req_valid = 4'b0010;
      tick();
      for (int b = 0; b < 4; b++) tick();
      req_valid = 4'b0100;
      tick();
      chk("t4_owner2", req_ready, 4'b0100);
      tick();
      tick();
      do_reset("t4_rst");
      req_valid = 4'b1111;
      chk("t4_post_idle", req_ready, 0);
      tick();
      chk("t4_first_grant", req_ready, 4'b0001);
      chk("t4_no_tag", res_tag_valid, 0);

      // Requester 3 alone: tag pulses every WIN+1 cycles.
      req_valid = 4'b1001;
      for (int b = 0; b < 4; b++) tick();
      req_valid = 4'b1000;
      last_pulse = -1;
      n_pulse = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (res_tag_valid && res_tag == 2'd3) begin
            if (last_pulse >= 0) chk("t5_spacing", c - last_pulse, WIN + 1);
            last_pulse = c;
            n_pulse++;
         end
      end
      chk("t5_pulse_count", 32'(n_pulse >= 4), 1);

      // Randomized valid toggling with per-requester sequence-numbered data.
      do_reset("rnd_rst");
      rnd_mode = 1'b1;
      w0 = wins;
      p0 = pulses;
      for (int c = 0; c < 1500; c++) begin
         xfer = req_valid & req_ready;
         tick();
         for (int i = 0; i < N_REQ; i++) begin
            if (xfer[i]) drv_seq[i] = drv_seq[i] + 14'd1;
            req_valid[i] = ($urandom_range(0, 3) != 0);
            set_data(i, {2'(i), drv_seq[i]});
         end
      end
      req_valid = '0;
      for (int c = 0; c < 12; c++) tick();
      chk("rnd_pulses_vs_windows", pulses - p0, wins - w0);
      chk("rnd_enough_windows", 32'((wins - w0) > 50), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pool_relu_sched.md
Name: pool_relu_sched

Overview:
- Round-robin window scheduler that shares one pool_ReLU datapath instance between N_REQ PE output streams.
- Grants one requester for a full pooling window of WIN beats, so the max-pool stage only ever sees contiguous samples from one source.
- Registers accepted beats into the pool_ReLU input and tags each window result with its source id, aligned to the datapath latency.
- Sits between the PE array output collectors and pool_ReLU.

Parameters:
- N_REQ, 4, number of requesting PE streams.
- DATA_WID, 16, sample width; equals the pool_ReLU DATA_WID.
- WIN, 4, beats per pooling window (2x2).
- POOL_LAT, 2, cycles from a pool_ReLU input beat to the corresponding output.
- ID_WID, 2, width of the requester id; must satisfy 2^ID_WID >= N_REQ.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*DATA_WID  per-requester sample; requester i occupies bits [i*DATA_WID +: DATA_WID].
- req_ready  out  N_REQ  per-requester accept; a beat transfers when valid & ready.
- pool_in_valid  out  1  beat valid into pool_ReLU.
- pool_in_data  out  DATA_WID  sample into pool_ReLU.
- pool_in_last  out  1  marks the final beat of a window.
- res_tag  out  ID_WID  source id of the window result leaving pool_ReLU.
- res_tag_valid  out  1  res_tag is valid this cycle.
- busy  out  1  high while a window is locked.

Behaviour:
- States: IDLE and LOCK.
- IDLE:
  - If any req_valid is high, latch owner as the first valid index searched upward from rr_ptr, with wrap.
  - Set beat_cnt=0 and go to LOCK.
  - req_ready is all zero in IDLE, so there is a one-cycle bubble per window.
- LOCK:
  - req_ready[owner]=1; all other ready bits are 0.
  - Each accepted beat increments beat_cnt.
  - A cycle where the owner's valid is low is a hold: no transfer, no timeout, no preemption.
- Window end: on the accepted beat with beat_cnt==WIN-1, set rr_ptr=(owner+1) mod N_REQ and go to IDLE.
- busy = (state==LOCK).
- Input pipeline:
  - pool_in_valid, pool_in_data and pool_in_last are registered, 1 cycle after the accepted beat.
  - pool_in_last is high only with the WIN-th beat.
  - pool_in_data holds its last value when pool_in_valid=0.
- Tag pipeline:
  - A shift register of depth POOL_LAT carries {last, owner} alongside each beat.
  - res_tag_valid equals pool_in_last delayed POOL_LAT cycles; res_tag is the matching owner.
  - Total latency from the final accepted beat to res_tag_valid is 1+POOL_LAT cycles.
- There is no downstream backpressure; pool_ReLU always accepts.
- Arithmetic:
  - beat_cnt is ceil(log2(WIN)) bits and wraps only through the window-end rule.
  - rr_ptr wraps modulo N_REQ; it is not a power-of-two wrap when N_REQ is not 2^k.
- A single requester valid every cycle gets back-to-back windows with one IDLE cycle between them. It wins again because the search wraps to it.
- A requester deasserting valid mid-window keeps its lock; the window resumes when it reasserts.
- Reset, asynchronous assert (reset low):
  - Go to IDLE; owner=0, rr_ptr=0, beat_cnt=0.
  - All outputs are 0: req_ready, pool_in_*, res_tag, res_tag_valid, busy.
  - Both pipelines are cleared.
- Reset mid-window: any partial window is discarded, and no res_tag_valid is produced for it.
- Reset deassertion: the block is synchronous to clk from deassertion onward, and arbitration starts from rr_ptr=0.

Test Plan:
- Reset then only req_valid[2]=1 with data 5,9,3,7 -> the IDLE cycle, then req_ready[2] high for 4 beats; pool_in_last with 7; res_tag_valid=1 with res_tag=2 three cycles later (POOL_LAT=2); busy low afterwards.
- All four requesters valid continuously -> windows granted in order 0,1,2,3,0; exactly 4 beats each; one-cycle bubble between windows; no ready bit high for a non-owner.
- Requester 1 locked and drops valid after beat 2 for 5 cycles while requester 3 is valid -> requester 3 is never granted; beats 3-4 come from requester 1 on reassertion; then rr_ptr=2 and requester 3 is granted next.
- Asynchronous reset asserted after 2 accepted beats -> all outputs 0 immediately without a clock edge; no res_tag_valid for the aborted window; after release, requester 0 is granted first.
- Only requester 3 valid repeatedly -> consecutive windows from owner 3, with res_tag=3 pulses spaced WIN+1=5 cycles apart.
- Randomised valid toggling -> each requester's samples reach pool_in_data in order, in groups of exactly WIN with pool_in_last on every 4th beat; the count of res_tag_valid pulses equals the number of completed windows.
